instr_fetch: RTL

Program-counter and fetch stage sitting directly upstream of the instruction ROM. Drives the ROM address, takes the combinational `instr`/`imm` pair back, works out instruction length (1 or 2 words) from the opcode, and advances the PC. Presents each fetched instruction, its immediate and its PC to the decoder through a registered valid/ready stage, with jump redirect and stall.

---
 rtl/instr_fetch.sv | 106 ++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Program counter and fetch stage feeding the decoder through a registered valid/ready stage.
// Optional ROM-end bounds checking with a sticky fault is enabled by defining INSTR_FETCH_BOUNDS_EN.
module instr_fetch #(
  parameter int unsigned          WORD_SIZE    = 8,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0,
  parameter logic [15:0]          IMM_MASK     = 16'h0002
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0] mem_instr,
  input  logic [WORD_SIZE-1:0] mem_imm,
  input  logic                 stall,
  input  logic                 jmp_en,
  input  logic [WORD_SIZE-1:0] jmp_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_instr,
  output logic [WORD_SIZE-1:0] out_imm,
  output logic [WORD_SIZE-1:0] out_pc
`ifdef INSTR_FETCH_BOUNDS_EN
  ,
  output logic                 fault
`endif
);

  localparam int unsigned OPC_LSB = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t               state;
  logic [WORD_SIZE-1:0] pc;
  logic [3:0]           opcode;
  logic                 is_long;
  logic [WORD_SIZE-1:0] pc_inc;
  logic                 adv;
`ifdef INSTR_FETCH_BOUNDS_EN
  logic                 oob;
`endif

  assign mem_addr = pc;

  // Instruction length decode and advance qualification
  always_comb begin
    opcode  = mem_instr[OPC_LSB +: 4];
    is_long = IMM_MASK[opcode];
    pc_inc  = is_long ? WORD_SIZE'(2) : WORD_SIZE'(1);
    adv     = (state == RUN) && !stall && !jmp_en && (!out_valid || out_ready);
`ifdef INSTR_FETCH_BOUNDS_EN
    // Immediate word would lie beyond the last ROM address
    oob     = is_long && (pc == '1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= RESET_VECTOR;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_imm   <= '0;
      out_pc    <= '0;
`ifdef INSTR_FETCH_BOUNDS_EN
      fault     <= 1'b0;
`endif
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
          if (jmp_en) begin
            pc        <= jmp_target;
            out_valid <= 1'b0;
          end
        end
        RUN: begin
          if (jmp_en) begin
            pc        <= jmp_target;
            out_valid <= 1'b0;
          end else if (adv) begin
`ifdef INSTR_FETCH_BOUNDS_EN
            if (oob) begin
              fault     <= 1'b1;
              state     <= FAULT;
              out_valid <= 1'b0;
            end else
`endif
            begin
              out_instr <= mem_instr;
              out_imm   <= is_long ? mem_imm : '0;
              out_pc    <= pc;
              out_valid <= 1'b1;
              pc        <= pc + pc_inc;
            end
          end
        end
        FAULT: out_valid <= 1'b0;
        default: state <= BOOT;
      endcase
    end
  end

endmodule
